// File: rtl/ibex_pkg.sv
// Shared types and constants for the reduced machine-mode CSR file.
package ibex_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum integer {
    RV32MNone        = 0,
    RV32MSlow        = 1,
    RV32MFast        = 2,
    RV32MSingleCycle = 3
  } rv32m_e;

  typedef enum integer {
    RV32BNone       = 0,
    RV32BBalanced   = 1,
    RV32BOTEarlGrey = 2,
    RV32BFull       = 3
  } rv32b_e;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  // Writable mstatus fields; MPP is hardwired to M-mode.
  typedef struct packed {
    logic tw;
    logic mprv;
    logic mpie;
    logic mie;
  } status_t;

  typedef enum logic [11:0] {
    CSR_MSTATUS       = 12'h300,
    CSR_MISA          = 12'h301,
    CSR_MIE           = 12'h304,
    CSR_MTVEC         = 12'h305,
    CSR_MCOUNTINHIBIT = 12'h320,
    CSR_MSCRATCH      = 12'h340,
    CSR_MEPC          = 12'h341,
    CSR_MCAUSE        = 12'h342,
    CSR_MTVAL         = 12'h343,
    CSR_MIP           = 12'h344,
    CSR_PMPCFG0       = 12'h3A0,
    CSR_PMPADDR0      = 12'h3B0,
    CSR_MCYCLE        = 12'hB00,
    CSR_MINSTRET      = 12'hB02,
    CSR_MCYCLEH       = 12'hB80,
    CSR_MINSTRETH     = 12'hB82,
    CSR_MVENDORID     = 12'hF11,
    CSR_MARCHID       = 12'hF12,
    CSR_MIMPID        = 12'hF13,
    CSR_MHARTID       = 12'hF14
  } csr_num_e;

  localparam int CSR_MSTATUS_MIE_BIT      = 3;
  localparam int CSR_MSTATUS_MPIE_BIT     = 7;
  localparam int CSR_MSTATUS_MPP_BIT_LOW  = 11;
  localparam int CSR_MSTATUS_MPP_BIT_HIGH = 12;
  localparam int CSR_MSTATUS_MPRV_BIT     = 17;
  localparam int CSR_MSTATUS_TW_BIT       = 21;

  localparam int CSR_MISA_B_BIT = 1;
  localparam int CSR_MISA_C_BIT = 2;
  localparam int CSR_MISA_E_BIT = 4;
  localparam int CSR_MISA_I_BIT = 8;
  localparam int CSR_MISA_M_BIT = 12;
  localparam int CSR_MISA_U_BIT = 20;

  localparam logic [31:0] CSR_MIE_MASK    = 32'h7FFF_0888;
  localparam logic [31:0] CSR_MCAUSE_MASK = 32'h8000_001F;

  // Architectural byte layout of one pmpcfg entry; bits [6:5] read as zero.
  function automatic logic [7:0] pmp_cfg_pack(input pmp_cfg_t cfg);
    return {cfg.lock, 2'b00, cfg.mode, cfg.exec, cfg.write, cfg.read};
  endfunction

endpackage

// File: rtl/ibex_counter.sv
// 64-bit-addressable performance counter with a configurable implemented width.
module ibex_counter
  import ibex_pkg::*;
#(
  parameter int unsigned Width = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] rdata_o
);

  localparam logic [63:0] CountMask = (Width >= 64) ? '1 : ((64'd1 << Width) - 64'd1);

  logic [63:0] count_q, count_d, count_inc;

  // Increment first, then let a write to either half override that half only.
  always_comb begin
    count_inc = count_q + {63'd0, inc_i};
    if (we_lo_i) count_inc[31:0]  = wdata_i;
    if (we_hi_i) count_inc[63:32] = wdata_i;
    count_d = count_inc & CountMask;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values of its neighbours; blocking here would create races.
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign rdata_o = count_q;

endmodule

// File: rtl/ibex_cs_regs.sv
// Machine-mode CSR file: combinational read port, read-modify-write on the clock edge.
module ibex_cs_regs
  import ibex_pkg::*;
#(
  parameter bit          DbgTriggerEn     = 1'b0,
  parameter bit          ICache           = 1'b0,
  parameter int unsigned MHPMCounterNum   = 8,
  parameter int unsigned MHPMCounterWidth = 40,
  parameter bit          PMPEnable        = 1'b0,
  parameter int unsigned PMPGranularity   = 0,
  parameter int unsigned PMPNumRegions    = 4,
  parameter bit          RV32E            = 1'b0,
  parameter bit          RV32T            = 1'b0,
  parameter rv32m_e      RV32M            = RV32MFast,
  parameter rv32b_e      RV32B            = RV32BNone
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        csr_access_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [1:0]  csr_op_i,
  input  logic        csr_op_en_i,
  output logic [31:0] csr_rdata_o,
  output logic        illegal_csr_insn_o
);

  localparam logic [31:0] MisaValue = 32'h4000_0000
      | (32'd1 << CSR_MISA_C_BIT)
      | (32'd1 << CSR_MISA_U_BIT)
      | (RV32E ? (32'd1 << CSR_MISA_E_BIT) : (32'd1 << CSR_MISA_I_BIT))
      | ((RV32M != RV32MNone) ? (32'd1 << CSR_MISA_M_BIT) : 32'd0)
      | ((RV32B != RV32BNone) ? (32'd1 << CSR_MISA_B_BIT) : 32'd0);

  // Inhibit bits exist for mcycle (0), minstret (2) and each implemented hpm counter.
  localparam logic [63:0] HpmBitsWide = (64'd1 << (MHPMCounterNum + 3)) - 64'd1;
  localparam logic [31:0] InhibitMask = HpmBitsWide[31:0] & 32'hFFFF_FFFD;

  localparam logic [31:0] NapotMask =
      (PMPGranularity >= 2) ? (((32'd1 << PMPGranularity) >> 1) - 32'd1) : 32'd0;
  localparam logic [31:0] TorMask =
      (PMPGranularity >= 1) ? ((32'd1 << PMPGranularity) - 32'd1) : 32'd0;

  logic unused_params;
  assign unused_params = DbgTriggerEn ^ ICache ^ RV32T;

  csr_op_e     csr_op;
  logic [4:0]  csr_idx;
  logic        is_cnt_lo, is_cnt_hi, is_hpmevent, is_pmpcfg, is_pmpaddr;
  logic        addr_valid, csr_wr_op, csr_we;
  logic [31:0] csr_rdata_int, csr_wval, mstatus_rdata;

  status_t     mstatus_q, mstatus_d;
  logic [31:0] mie_q, mie_d, mscratch_q, mscratch_d, mtval_q, mtval_d;
  logic [31:0] mcountinhibit_q, mcountinhibit_d;
  logic [23:0] mtvec_q, mtvec_d;
  logic [30:0] mepc_q, mepc_d;
  logic        mcause_int_q, mcause_int_d;
  logic [4:0]  mcause_code_q, mcause_code_d;

  logic [63:0] cnt_rdata [32];
  pmp_cfg_t    pmp_cfg [16];
  logic [7:0]  pmp_cfg_rdata [16];
  logic [31:0] pmp_addr_rdata [16];

  assign csr_op      = csr_op_e'(csr_op_i);
  assign csr_idx     = csr_addr_i[4:0];
  assign is_cnt_lo   = (csr_addr_i[11:5] == 7'h58);
  assign is_cnt_hi   = (csr_addr_i[11:5] == 7'h5C);
  assign is_hpmevent = (csr_addr_i[11:5] == 7'h19) && (csr_idx >= 5'd3);
  assign is_pmpcfg   = (csr_addr_i[11:2] == 10'h0E8);
  assign is_pmpaddr  = (csr_addr_i[11:4] == 8'h3B);

  // Assemble mstatus from its stored fields plus the fixed MPP encoding.
  always_comb begin
    mstatus_rdata = '0;
    mstatus_rdata[CSR_MSTATUS_MIE_BIT]  = mstatus_q.mie;
    mstatus_rdata[CSR_MSTATUS_MPIE_BIT] = mstatus_q.mpie;
    mstatus_rdata[CSR_MSTATUS_MPP_BIT_HIGH:CSR_MSTATUS_MPP_BIT_LOW] = 2'b11;
    mstatus_rdata[CSR_MSTATUS_MPRV_BIT] = mstatus_q.mprv;
    mstatus_rdata[CSR_MSTATUS_TW_BIT]   = mstatus_q.tw;
  end

  // Read mux; also decides whether the address names an implemented CSR.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would otherwise infer a latch.
    csr_rdata_int = '0;
    addr_valid    = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS:       csr_rdata_int = mstatus_rdata;
      CSR_MISA:          csr_rdata_int = MisaValue;
      CSR_MIE:           csr_rdata_int = mie_q;
      CSR_MIP:           csr_rdata_int = '0;
      CSR_MTVEC:         csr_rdata_int = {mtvec_q, 6'd0, 2'b01};
      CSR_MSCRATCH:      csr_rdata_int = mscratch_q;
      CSR_MEPC:          csr_rdata_int = {mepc_q, 1'b0};
      CSR_MCAUSE:        csr_rdata_int = {mcause_int_q, 26'd0, mcause_code_q};
      CSR_MTVAL:         csr_rdata_int = mtval_q;
      CSR_MCOUNTINHIBIT: csr_rdata_int = mcountinhibit_q;
      CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID, CSR_MHARTID: csr_rdata_int = '0;
      default: begin
        if ((is_cnt_lo || is_cnt_hi) && (csr_idx != 5'd1)) begin
          csr_rdata_int = is_cnt_hi ? cnt_rdata[csr_idx][63:32] : cnt_rdata[csr_idx][31:0];
        end else if (is_hpmevent) begin
          if ({27'd0, csr_idx} < (32'(MHPMCounterNum) + 32'd3)) csr_rdata_int = 32'd1 << csr_idx;
        end else if (PMPEnable && is_pmpcfg) begin
          for (int b = 0; b < 4; b++) begin
            csr_rdata_int[8*b +: 8] = pmp_cfg_rdata[{csr_idx[1:0], 2'(b)}];
          end
        end else if (PMPEnable && is_pmpaddr) begin
          csr_rdata_int = pmp_addr_rdata[csr_idx[3:0]];
        end else begin
          addr_valid = 1'b0;
        end
      end
    endcase
  end

  assign csr_rdata_o        = csr_rdata_int;
  assign csr_wr_op          = (csr_op != CSR_OP_READ);
  assign illegal_csr_insn_o = csr_access_i &
                              (~addr_valid | ((csr_addr_i[11:10] == 2'b11) & csr_wr_op));
  assign csr_we             = csr_access_i & csr_op_en_i & csr_wr_op & ~illegal_csr_insn_o;

  // Read-modify-write value derived from the current read data.
  always_comb begin
    case (csr_op)
      CSR_OP_WRITE: csr_wval = csr_wdata_i;
      CSR_OP_SET:   csr_wval = csr_wdata_i | csr_rdata_int;
      CSR_OP_CLEAR: csr_wval = csr_rdata_int & ~csr_wdata_i;
      default:      csr_wval = csr_rdata_int;
    endcase
  end

  // Next state of the plain machine CSRs, applying each field's write mask.
  always_comb begin
    mstatus_d       = mstatus_q;
    mie_d           = mie_q;
    mtvec_d         = mtvec_q;
    mscratch_d      = mscratch_q;
    mepc_d          = mepc_q;
    mcause_int_d    = mcause_int_q;
    mcause_code_d   = mcause_code_q;
    mtval_d         = mtval_q;
    mcountinhibit_d = mcountinhibit_q;
    if (csr_we) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_d.mie  = csr_wval[CSR_MSTATUS_MIE_BIT];
          mstatus_d.mpie = csr_wval[CSR_MSTATUS_MPIE_BIT];
          mstatus_d.mprv = csr_wval[CSR_MSTATUS_MPRV_BIT];
          mstatus_d.tw   = csr_wval[CSR_MSTATUS_TW_BIT];
        end
        CSR_MIE:      mie_d      = csr_wval & CSR_MIE_MASK;
        CSR_MTVEC:    mtvec_d    = csr_wval[31:8];
        CSR_MSCRATCH: mscratch_d = csr_wval;
        CSR_MEPC:     mepc_d     = csr_wval[31:1];
        CSR_MCAUSE: begin
          mcause_int_d  = csr_wval[31];
          mcause_code_d = csr_wval[4:0];
        end
        CSR_MTVAL:         mtval_d         = csr_wval;
        CSR_MCOUNTINHIBIT: mcountinhibit_d = csr_wval & InhibitMask;
        default: ;
      endcase
    end
  end

  // CSR state registers; reset is synchronous and takes priority over a write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mstatus_q       <= '0;
      mie_q           <= '0;
      mtvec_q         <= '0;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_int_q    <= 1'b0;
      mcause_code_q   <= '0;
      mtval_q         <= '0;
      mcountinhibit_q <= '0;
    end else begin
      mstatus_q       <= mstatus_d;
      mie_q           <= mie_d;
      mtvec_q         <= mtvec_d;
      mscratch_q      <= mscratch_d;
      mepc_q          <= mepc_d;
      mcause_int_q    <= mcause_int_d;
      mcause_code_q   <= mcause_code_d;
      mtval_q         <= mtval_d;
      mcountinhibit_q <= mcountinhibit_d;
    end
  end

  // Counter slots: 0 mcycle, 2 minstret, 3.. hpm counters; slot 1 and the rest read 0.
  for (genvar i = 0; i < 32; i++) begin : gen_cnt
    if ((i == 0) || (i == 2) || ((i >= 3) && (i < 3 + MHPMCounterNum))) begin : gen_impl
      ibex_counter #(
        .Width((i < 3) ? 64 : MHPMCounterWidth)
      ) u_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   ((i == 0) ? ~mcountinhibit_q[0] : 1'b0),
        .we_lo_i (csr_we & is_cnt_lo & (csr_idx == 5'(i))),
        .we_hi_i (csr_we & is_cnt_hi & (csr_idx == 5'(i))),
        .wdata_i (csr_wval),
        .rdata_o (cnt_rdata[i])
      );
    end else begin : gen_none
      assign cnt_rdata[i] = '0;
    end
  end

  // PMP regions: each holds one cfg byte and one address, subject to locking.
  for (genvar i = 0; i < 16; i++) begin : gen_pmp
    if (PMPEnable && (i < PMPNumRegions)) begin : gen_region
      localparam int Lsb = 8 * (i % 4);
      pmp_cfg_t    cfg_q, cfg_d;
      logic [31:0] addr_q;
      logic        cfg_we, addr_we, tor_locked;

      if (i + 1 < PMPNumRegions) begin : gen_tor_lock
        assign tor_locked = pmp_cfg[i+1].lock & (pmp_cfg[i+1].mode == PMP_MODE_TOR);
      end else begin : gen_no_tor_lock
        assign tor_locked = 1'b0;
      end

      assign cfg_we  = csr_we & is_pmpcfg & (csr_idx[1:0] == 2'(i / 4)) & ~cfg_q.lock;
      assign addr_we = csr_we & is_pmpaddr & (csr_idx[3:0] == 4'(i)) & ~cfg_q.lock & ~tor_locked;

      // Legalise the incoming cfg byte: W needs R, and NA4 is unavailable when G>=1.
      always_comb begin
        cfg_d.read  = csr_wval[Lsb];
        cfg_d.write = csr_wval[Lsb+1] & csr_wval[Lsb];
        cfg_d.exec  = csr_wval[Lsb+2];
        cfg_d.mode  = pmp_cfg_mode_e'(csr_wval[Lsb+3 +: 2]);
        cfg_d.lock  = csr_wval[Lsb+7];
        if ((PMPGranularity >= 1) && (cfg_d.mode == PMP_MODE_NA4)) cfg_d.mode = cfg_q.mode;
      end

      // Region registers.
      always_ff @(posedge clk_i) begin
        // NOTE: PMP state is reset like any other register so a region can
        // never come out of reset with a stale lock bit set.
        if (!rst_ni) begin
          cfg_q  <= '0;
          addr_q <= '0;
        end else begin
          if (cfg_we)  cfg_q  <= cfg_d;
          if (addr_we) addr_q <= csr_wval;
        end
      end

      assign pmp_cfg[i]        = cfg_q;
      assign pmp_addr_rdata[i] = (cfg_q.mode == PMP_MODE_NAPOT) ? (addr_q | NapotMask) :
                                 (cfg_q.mode == PMP_MODE_NA4)   ? addr_q :
                                                                  (addr_q & ~TorMask);
    end else begin : gen_no_region
      assign pmp_cfg[i]        = '0;
      assign pmp_addr_rdata[i] = '0;
    end
    assign pmp_cfg_rdata[i] = pmp_cfg_pack(pmp_cfg[i]);
  end

endmodule

// File: tb/tb_ibex_cs_regs.sv
// Directed bench for the CSR file: reset values, RMW ops, legality, counters, PMP.
module tb_ibex_cs_regs;
  import ibex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_access;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_op;
  logic        csr_op_en;
  logic [31:0] csr_rdata;
  logic        illegal;

  int vec_count   = 0;
  int miscompares = 0;

  ibex_cs_regs #(
    .MHPMCounterNum   (8),
    .MHPMCounterWidth (40),
    .PMPEnable        (1'b1),
    .PMPGranularity   (0),
    .PMPNumRegions    (4)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .csr_access_i       (csr_access),
    .csr_addr_i         (csr_addr),
    .csr_wdata_i        (csr_wdata),
    .csr_op_i           (csr_op),
    .csr_op_en_i        (csr_op_en),
    .csr_rdata_o        (csr_rdata),
    .illegal_csr_insn_o (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One CSR access: driven after the falling edge, sampled 1ns later, committed at the rising edge.
  task automatic csr_acc(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic ill);
    @(negedge clk);
    csr_access = 1'b1;
    csr_addr   = addr;
    csr_op     = op;
    csr_wdata  = wdata;
    csr_op_en  = 1'b1;
    #1;
    rdata = csr_rdata;
    ill   = illegal;
    @(posedge clk);
    #1;
    csr_access = 1'b0;
    csr_op_en  = 1'b0;
    csr_op     = 2'd0;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    logic        ill;
    csr_acc(addr, 2'd0, 32'd0, r, ill);
    check(tag, r, exp);
  endtask

  task automatic wr(input string tag, input logic [11:0] addr, input logic [1:0] op,
                    input logic [31:0] wdata, input logic exp_ill);
    logic [31:0] r;
    logic        ill;
    csr_acc(addr, op, wdata, r, ill);
    check({tag, "_ill"}, {31'd0, ill}, {31'd0, exp_ill});
  endtask

  initial begin
    logic [31:0] r;
    logic        ill;
    rst_n = 1'b0; csr_access = 1'b0; csr_addr = '0; csr_wdata = '0; csr_op = '0; csr_op_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values
    rd("mtvec_rst", 12'h305, 32'h0000_0001);
    rd("mstatus_rst", 12'h300, 32'h0000_1800);
    csr_acc(12'h301, 2'd0, 32'd0, r, ill);
    check("misa_rst", r & 32'hFFEF_FFFF, 32'h4000_1104);
    check("misa_ill", {31'd0, ill}, 32'd0);

    // Read-modify-write ops on mscratch
    wr("mscratch_w", 12'h340, 2'd1, 32'hA5A5_A5A5, 1'b0);
    wr("mscratch_s", 12'h340, 2'd2, 32'h0000_000F, 1'b0);
    rd("mscratch_after_set", 12'h340, 32'hA5A5_A5AF);
    wr("mscratch_c", 12'h340, 2'd3, 32'h0000_00F0, 1'b0);
    rd("mscratch_rmw", 12'h340, 32'hA5A5_A50F);

    // Field masks on the other machine CSRs
    wr("mstatus_w", 12'h300, 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("mstatus_mask", 12'h300, 32'h0022_1888);
    wr("mie_w", 12'h304, 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("mie_mask", 12'h304, 32'h7FFF_0888);
    wr("mtvec_w", 12'h305, 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("mtvec_mask", 12'h305, 32'hFFFF_FF01);
    wr("mepc_w", 12'h341, 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("mepc_mask", 12'h341, 32'hFFFF_FFFE);
    wr("mcause_w", 12'h342, 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("mcause_mask", 12'h342, 32'h8000_001F);
    wr("mip_w", 12'h344, 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("mip_zero", 12'h344, 32'h0000_0000);

    // Legality
    wr("mhartid_w", 12'hF14, 2'd1, 32'h0000_0000, 1'b1);
    wr("marchid_set0", 12'hF12, 2'd2, 32'h0000_0000, 1'b1);
    wr("mhartid_rd", 12'hF14, 2'd0, 32'h0000_0000, 1'b0);
    rd("mhartid_val", 12'hF14, 32'h0000_0000);
    wr("unimpl_rd", 12'h7B0, 2'd0, 32'h0000_0000, 1'b1);
    wr("cnt1_rd", 12'hB01, 2'd0, 32'h0000_0000, 1'b1);
    @(negedge clk);
    csr_access = 1'b0; csr_addr = 12'h7B0;
    #1 check("no_access_ill", {31'd0, illegal}, 32'd0);

    // mcycle: freeze, carry into the high half, write beats increment
    wr("inhibit_w", 12'h320, 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("inhibit_mask", 12'h320, 32'h0000_07FD);
    wr("mcycleh_w", 12'hB80, 2'd1, 32'h0000_0000, 1'b0);
    wr("mcycle_w", 12'hB00, 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("mcycle_frozen", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycleh_frozen", 12'hB80, 32'h0000_0000);
    rd("mcycle_frozen2", 12'hB00, 32'hFFFF_FFFF);
    wr("inhibit_clr", 12'h320, 2'd1, 32'h0000_0000, 1'b0);
    // The first increment happens on the edge after the inhibit clear commits.
    @(posedge clk);
    rd("mcycleh_carry", 12'hB80, 32'h0000_0001);
    wr("mcycle_w2", 12'hB00, 2'd1, 32'h0000_0100, 1'b0);
    rd("mcycle_write_wins", 12'hB00, 32'h0000_0100);
    rd("mcycleh_kept", 12'hB80, 32'h0000_0001);

    // minstret only changes on writes
    wr("minstret_w", 12'hB02, 2'd1, 32'h0000_DEAD, 1'b0);
    rd("minstret_hold", 12'hB02, 32'h0000_DEAD);
    rd("minstret_hold2", 12'hB02, 32'h0000_DEAD);

    // hpm counters and events
    wr("hpm3h_w", 12'hB83, 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("hpm3h_trunc", 12'hB83, 32'h0000_00FF);
    wr("hpm3_w", 12'hB03, 2'd1, 32'h1234_5678, 1'b0);
    rd("hpm3_val", 12'hB03, 32'h1234_5678);
    rd("hpm3_no_events", 12'hB03, 32'h1234_5678);
    wr("hpm11_w", 12'hB0B, 2'd1, 32'h0000_0055, 1'b0);
    rd("hpm11_zero", 12'hB0B, 32'h0000_0000);
    wr("hpm31_w", 12'hB1F, 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("hpm31_zero", 12'hB1F, 32'h0000_0000);
    rd("hpmevent3", 12'h323, 32'h0000_0008);
    rd("hpmevent10", 12'h32A, 32'h0000_0400);
    rd("hpmevent11", 12'h32B, 32'h0000_0000);

    // PMP: W requires R, lock freezes cfg byte and address, TOR lock reaches pmpaddr[i-1]
    wr("pmpaddr0_w", 12'h3B0, 2'd1, 32'h0000_1234, 1'b0);
    rd("pmpaddr0_val", 12'h3B0, 32'h0000_1234);
    wr("pmpcfg0_w", 12'h3A0, 2'd1, 32'h0000_0082, 1'b0);
    rd("pmpcfg0_lock", 12'h3A0, 32'h0000_0080);
    wr("pmpaddr0_locked", 12'h3B0, 2'd1, 32'h0000_5678, 1'b0);
    rd("pmpaddr0_hold", 12'h3B0, 32'h0000_1234);
    wr("pmpaddr1_w", 12'h3B1, 2'd1, 32'h0000_AAAA, 1'b0);
    wr("pmpcfg0_w2", 12'h3A0, 2'd1, 32'h0088_0F00, 1'b0);
    rd("pmpcfg0_bytes", 12'h3A0, 32'h0088_0F80);
    wr("pmpaddr1_torlock", 12'h3B1, 2'd1, 32'h0000_BBBB, 1'b0);
    rd("pmpaddr1_hold", 12'h3B1, 32'h0000_AAAA);
    wr("pmpaddr5_w", 12'h3B5, 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("pmpaddr5_zero", 12'h3B5, 32'h0000_0000);
    rd("pmpcfg1_zero", 12'h3A1, 32'h0000_0000);

    // Reset asserted during a write: reset wins
    @(negedge clk);
    rst_n = 1'b0; csr_access = 1'b1; csr_addr = 12'h340; csr_op = 2'd1;
    csr_wdata = 32'h0000_0055; csr_op_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1; csr_access = 1'b0; csr_op_en = 1'b0; csr_op = 2'd0;
    rd("mscratch_reset_wins", 12'h340, 32'h0000_0000);
    rd("mstatus_rst2", 12'h300, 32'h0000_1800);
    rd("pmpcfg0_rst", 12'h3A0, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
